// File: rtl/acq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : acq_scheduler
// Purpose  : Round-robin owner of a shared BRAM acquisition write port. A
//            granted requester waits for the free-running address to wrap,
//            then the write enable runs for num_sweeps full address sweeps.
//            The address wrap period is measured independently.
// Revision : 1.0 - initial release
// ============================================================================
module acq_scheduler #(
  parameter int BRAM_WIDTH       = 13,
  parameter int N_REQ            = 4,
  parameter int NUM_SWEEPS_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [N_REQ-1:0]            req,
  input  logic [NUM_SWEEPS_WIDTH-1:0] num_sweeps,
  input  logic [BRAM_WIDTH-1:0]       address,
  output logic [N_REQ-1:0]            grant,
  output logic                        wen,
  output logic [NUM_SWEEPS_WIDTH-1:0] sweep_index,
  output logic [N_REQ-1:0]            done,
  output logic                        busy,
  output logic [31:0]                 period
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                      r_state;
  logic [N_REQ-1:0]            r_grant;
  logic                        r_wen;
  logic [NUM_SWEEPS_WIDTH-1:0] r_sweep_idx;
  logic [N_REQ-1:0]            r_done;
  logic                        r_busy;
  logic [IDX_W-1:0]            r_rr_ptr;
  logic [IDX_W-1:0]            r_owner;
  logic [NUM_SWEEPS_WIDTH-1:0] r_latched;
  logic [BRAM_WIDTH-1:0]       r_word_cnt;
  logic [31:0]                 r_wrap_cnt;
  logic [31:0]                 r_period;

  logic [IDX_W-1:0]            w_winner;
  logic [IDX_W-1:0]            w_cand;
  logic [NUM_SWEEPS_WIDTH-1:0] w_sweeps;
  logic                        w_last_sweep;
  logic                        w_addr_zero;

  assign w_sweeps     = (num_sweeps == '0) ? NUM_SWEEPS_WIDTH'(1) : num_sweeps;
  assign w_last_sweep = (r_sweep_idx == (r_latched - NUM_SWEEPS_WIDTH'(1)));
  assign w_addr_zero  = (address == '0);

  // Cyclic search starting just after the RR pointer; scanning from the far
  // end lets the nearest set bit overwrite farther ones without a break.
  always_comb begin
    w_winner = r_rr_ptr;
    w_cand   = r_rr_ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + i) % N_REQ);
      if (req[w_cand]) begin
        w_winner = w_cand;
      end
    end
  end

  // Scheduler FSM: grant, wait for address wrap, write whole sweeps, release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_wen       <= 1'b0;
      r_sweep_idx <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
      r_rr_ptr    <= IDX_W'(N_REQ - 1);
      r_owner     <= '0;
      r_latched   <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
            r_busy    <= 1'b1;
            r_rr_ptr  <= w_winner;
            r_owner   <= w_winner;
            r_latched <= w_sweeps;
            r_state   <= S_ARM;
          end
        end
        S_ARM: begin
          // A withdrawn request outranks a simultaneous address wrap.
          if (!req[r_owner]) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_addr_zero) begin
            r_wen       <= 1'b1;
            r_word_cnt  <= '0;
            r_sweep_idx <= '0;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_word_cnt <= r_word_cnt + BRAM_WIDTH'(1);
          if (&r_word_cnt) begin
            if (w_last_sweep) begin
              r_wen   <= 1'b0;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_done  <= r_grant;
              r_state <= S_IDLE;
            end else begin
              r_sweep_idx <= r_sweep_idx + NUM_SWEEPS_WIDTH'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Wrap-period meter: saturating cycle counter restarted at each address==0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wrap_cnt <= '0;
      r_period   <= '0;
    end else if (w_addr_zero) begin
      r_period   <= (&r_wrap_cnt) ? r_wrap_cnt : r_wrap_cnt + 32'd1;
      r_wrap_cnt <= '0;
    end else if (!(&r_wrap_cnt)) begin
      r_wrap_cnt <= r_wrap_cnt + 32'd1;
    end
  end

  assign grant       = r_grant;
  assign wen         = r_wen;
  assign sweep_index = r_sweep_idx;
  assign done        = r_done;
  assign busy        = r_busy;
  assign period      = r_period;

endmodule
`default_nettype wire

// File: tb/tb_acq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_acq_scheduler
// Purpose  : Self-checking bench for acq_scheduler (BRAM_WIDTH=4, N_REQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_acq_scheduler;

  logic       clk;
  logic       resetn;
  logic [3:0] req;
  logic [7:0] num_sweeps;
  logic [3:0] address;
  logic [3:0] grant;
  logic       wen;
  logic [7:0] sweep_index;
  logic [3:0] done;
  logic       busy;
  logic [31:0] period;

  int n_checks;
  int n_fail;

  // reference model state
  int rr_ptr;
  int edge_num;
  int last_zero;
  int exp_period;
  logic addr_run;

  acq_scheduler #(
    .BRAM_WIDTH       (4),
    .N_REQ            (4),
    .NUM_SWEEPS_WIDTH (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .num_sweeps  (num_sweeps),
    .address     (address),
    .grant       (grant),
    .wen         (wen),
    .sweep_index (sweep_index),
    .done        (done),
    .busy        (busy),
    .period      (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First requester found cyclically after the last winner.
  function automatic int pick(input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      if (r[(rr_ptr + i) % 4]) return (rr_ptr + i) % 4;
    end
    return 0;
  endfunction

  // One clock: address seen at the edge feeds the period model; the
  // address generator then advances after the edge.
  task automatic step();
    logic [3:0] a;
    a = address;
    @(posedge clk);
    if (!resetn) begin
      edge_num   = 0;
      last_zero  = 0;
      exp_period = 0;
    end else begin
      edge_num++;
      if (a == 4'd0) begin
        exp_period = edge_num - last_zero;
        last_zero  = edge_num;
      end
    end
    #1;
    if (addr_run) address = address + 4'd1;
  endtask

  // One full acquisition starting from IDLE with req already driven.
  // mode: 0 keep req, 1 scramble req during WRITE, 2 clear req during WRITE.
  task automatic run_acq(input int mode, input string tag);
    int         own;
    int         s;
    logic [3:0] oh;
    logic       a0;
    bit         got;
    own    = pick(req);
    oh     = 4'b0001 << own;
    s      = (num_sweeps == 8'd0) ? 1 : int'(num_sweeps);
    rr_ptr = own;
    step();
    n_checks++;
    if (grant !== oh || busy !== 1'b1 || wen !== 1'b0) begin
      n_fail++;
      $display("FAIL %s grant: grant=%b busy=%b wen=%b, expected grant=%b busy=1 wen=0",
               tag, grant, busy, wen, oh);
    end
    num_sweeps = 8'($urandom_range(0, 255));
    got = 0;
    for (int c = 0; c < 40; c++) begin
      a0 = (address == 4'd0);
      step();
      n_checks++;
      if (wen !== a0 || grant !== oh) begin
        n_fail++;
        $display("FAIL %s arm: wen=%b grant=%b, expected wen=%b grant=%b",
                 tag, wen, grant, a0, oh);
      end
      if (a0) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s arm_timeout: wen=%b, expected 1 within 40 cycles", tag, wen);
      return;
    end
    for (int j = 0; j < s * 16; j++) begin
      n_checks++;
      if (wen !== 1'b1 || sweep_index !== 8'(j / 16) || grant !== oh || done !== 4'd0) begin
        n_fail++;
        $display("FAIL %s write[%0d]: wen=%b idx=%0d grant=%b done=%b, expected wen=1 idx=%0d grant=%b done=0000",
                 tag, j, wen, sweep_index, grant, done, j / 16, oh);
      end
      if (mode == 1 && $urandom_range(0, 15) == 0) req = 4'($urandom);
      if (mode == 2 && j == 5) req = 4'd0;
      step();
    end
    n_checks++;
    if (wen !== 1'b0 || done !== oh || grant !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: wen=%b done=%b grant=%b busy=%b, expected wen=0 done=%b grant=0000 busy=0",
               tag, wen, done, grant, busy, oh);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    n_checks++;
    if (grant !== 4'd0 || wen !== 1'b0 || busy !== 1'b0 || done !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: grant=%b wen=%b busy=%b done=%b, expected all 0",
               grant, wen, busy, done);
    end
    n_checks++;
    if (sweep_index !== 8'd0 || period !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: sweep_index=%0d period=%0d, expected 0 0", sweep_index, period);
    end
    resetn = 1'b1;
    rr_ptr = 3;
  endtask

  task automatic test_round_robin();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      num_sweeps = 8'd1;
      run_acq(0, "rr");
    end
    req = 4'd0;
    step();
  endtask

  task automatic test_single();
    req        = 4'b0001;
    num_sweeps = 8'd1;
    run_acq(0, "single");
    req = 4'd0;
    step();
    n_checks++;
    if (done !== 4'd0 || grant !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: done=%b grant=%b busy=%b, expected 0", done, grant, busy);
    end
  endtask

  task automatic test_multi_sweep();
    req        = 4'b0100;
    num_sweeps = 8'd3;
    run_acq(0, "sweeps3");
    req = 4'd0;
    step();
    req        = 4'b0100;
    num_sweeps = 8'd0;
    run_acq(0, "sweeps0");
    req = 4'd0;
    step();
  endtask

  task automatic test_withdraw();
    int         own;
    logic [3:0] oh;
    bit         got;
    req    = 4'b0010;
    num_sweeps = 8'd1;
    own    = pick(req);
    oh     = 4'b0001 << own;
    rr_ptr = own;
    step();
    n_checks++;
    if (grant !== oh) begin
      n_fail++;
      $display("FAIL withdraw_grant: grant=%b, expected %b", grant, oh);
    end
    // drop the request on the very cycle the address wrap is sampled
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (address == 4'd0) begin
        got = 1;
        break;
      end
      step();
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL withdraw_timeout: address never reached 0, expected within 40 cycles");
    end
    req = 4'd0;
    step();
    n_checks++;
    if (grant !== 4'd0 || busy !== 1'b0 || wen !== 1'b0 || done !== 4'd0) begin
      n_fail++;
      $display("FAIL withdraw_abort: grant=%b busy=%b wen=%b done=%b, expected all 0",
               grant, busy, wen, done);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (done !== 4'd0 || wen !== 1'b0) begin
        n_fail++;
        $display("FAIL withdraw_quiet: done=%b wen=%b, expected 0 0", done, wen);
      end
    end
    req        = 4'b1000;
    num_sweeps = 8'd2;
    run_acq(2, "drop_in_write");
    req = 4'd0;
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      req        = 4'($urandom_range(1, 15));
      num_sweeps = 8'($urandom_range(0, 2));
      run_acq(1, "random");
    end
    req = 4'd0;
    step();
  endtask

  task automatic test_period();
    for (int k = 0; k < 80; k++) begin
      addr_run = ($urandom_range(0, 3) != 0);
      step();
      n_checks++;
      if (period !== 32'(exp_period)) begin
        n_fail++;
        $display("FAIL period_random: period=%0d, expected %0d", period, exp_period);
      end
    end
    addr_run = 1'b1;
    repeat (40) step();
    n_checks++;
    if (period !== 32'(exp_period) || period !== 32'd16) begin
      n_fail++;
      $display("FAIL period_steady: period=%0d, expected %0d (16)", period, exp_period);
    end
  endtask

  task automatic test_reset_mid_write();
    bit got;
    req        = 4'b0001;
    num_sweeps = 8'd2;
    rr_ptr     = pick(req);
    step();
    got = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (wen === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL rst_mid_timeout: wen=%b, expected 1 within 40 cycles", wen);
    end
    repeat (3) step();
    #3;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (wen !== 1'b0 || grant !== 4'd0 || busy !== 1'b0 || done !== 4'd0 ||
        period !== 32'd0 || sweep_index !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid_write: wen=%b grant=%b busy=%b done=%b period=%0d idx=%0d, expected all 0",
               wen, grant, busy, done, period, sweep_index);
    end
    req = 4'd0;
    repeat (2) step();
    resetn = 1'b1;
    rr_ptr = 3;
    // pointer restarts so requester 0 wins first again
    req        = 4'b1111;
    num_sweeps = 8'd1;
    run_acq(0, "after_reset");
    req = 4'd0;
    step();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rr_ptr     = 3;
    edge_num   = 0;
    last_zero  = 0;
    exp_period = 0;
    addr_run   = 1'b1;
    resetn     = 1'b0;
    req        = 4'd0;
    num_sweeps = 8'd0;
    address    = 4'd0;

    test_reset();
    test_round_robin();
    test_single();
    test_multi_sweep();
    test_withdraw();
    test_random();
    test_period();
    test_reset_mid_write();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
